hex_scan_ctrl: RTL
==================

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000, clock cycles per digit slot (legal range DIV >= 2).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port wr_valid  input  1  write request.
REQ-005 SHALL have port wr_ready  output  1  write acceptance; a transfer occurs when wr_valid && wr_ready at a rising edge.
REQ-006 SHALL have port wr_data  input  16  four hex nibbles; digit k = wr_data[4k+3:4k].
REQ-007 SHALL have port wr_blank  input  4  per-digit blank mask; bit k=1 blanks digit k; captured with wr_data.
REQ-008 SHALL have port lz_en  input  1  leading-zero suppression enable, sampled live.
REQ-009 SHALL have port an  output  4  digit enables, active-low, bit k = digit k.
REQ-010 SHALL have port seg  output  7  segments, active-low, bit0=a .. bit6=g.
REQ-011 SHALL have port digit_sel  output  2  index of the digit slot currently scanned.

Function
REQ-012 SHALL keep a slot counter cnt running 0..DIV-1 and then wrapping to 0; when cnt wraps, idx SHALL advance 0->1->2->3->0.
REQ-013 digit_sel SHALL equal idx.
REQ-014 SHALL instantiate exactly one hex_disp decoder, shared across all digits, fed the displayed nibble of digit idx.
REQ-015 an and seg SHALL be combinational functions of registered state only (cnt, idx, display registers, lz_en); they SHALL NOT be latched.
REQ-016 When cnt==0 (anti-ghost gap), an SHALL be 4'b1111.
REQ-017 When cnt!=0 and digit idx is not blanked, an SHALL be ~(4'b0001 << idx), and seg SHALL be the decoder output.
REQ-018 A digit SHALL be blanked if its disp_blank bit is 1 or it is leading-zero suppressed; when blanked, an SHALL be 4'b1111 and seg SHALL be 7'b1111111.
REQ-019 Leading-zero suppression: with lz_en=1, digit k (k=3,2,1) SHALL be suppressed when its nibble and every higher nibble are 0; digit 0 SHALL never be suppressed.
REQ-020 Frame boundary SHALL be the cycle with idx==3 and cnt==DIV-1.
REQ-021 The handshake FSM SHALL have two states: EMPTY (wr_ready=1) and PENDING (wr_ready=0).
REQ-022 A transfer in EMPTY on a non-boundary cycle SHALL store data and mask into the pending buffer and go to PENDING.
REQ-023 A transfer in EMPTY on a boundary cycle SHALL load the display registers directly and remain in EMPTY.
REQ-024 In PENDING, at the boundary edge the pending buffer SHALL be copied to the display registers and the FSM SHALL return to EMPTY, so wr_ready=1 from the next cycle.
REQ-025 Display registers SHALL change only at boundary edges (no tearing within a frame).
REQ-026 wr_valid while wr_ready=0 SHALL be ignored; the requester holds it.

Reset
REQ-027 While rst=1, independent of clk: cnt=0, idx=0, display value=16'h0000, disp_blank=4'b1111, pending cleared, FSM in EMPTY, wr_ready=0, an=4'b1111, seg=7'b1111111.
REQ-028 After rst deasserts, wr_ready SHALL be 1 and scanning SHALL start at idx=0, cnt=0; reset mid-transfer SHALL discard the pending data.

Verification (DIV=4)
REQ-029 Assert rst mid-slot with idx=2 -> an=4'b1111, seg=7'b1111111, wr_ready=0 in the same cycle; after release digit_sel=0, and the first 4 an values are 1111,1111,1111,1111.
REQ-030 Write 16'h12AF, mask 0, lz_en=0, accepted at idx=0 -> wr_ready=0 until the boundary; next frame: digit0 seg=0001110, digit1 seg=0001000, digit2 seg=0100100, digit3 seg=1111001, with an=1110/1101/1011/0111 for cnt=1..3.
REQ-031 Hold a second write of 16'h3333 during PENDING -> not accepted until the cycle after the boundary; the frame after REQ-030 shows 12AF unbroken.
REQ-032 Write 16'h0005 with lz_en=1 -> digits 3..1 keep an=1111 for the whole slot; digit0 seg=0010010.
REQ-033 Write 16'h0000 with lz_en=1 -> only digit0 is lit, seg=1000000; write with mask 4'b0001 -> all four digits dark.
REQ-034 Transfer accepted on the boundary cycle -> data is displayed from idx=0 of the next frame, and wr_ready stays 1.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
// Four-digit multiplexed hex display scanner with a single shared segment
// decoder, per-digit blanking, leading-zero suppression and a valid/ready
// write port whose updates take effect only on frame boundaries.

// Hex nibble to active-low 7-segment pattern, bit0=a .. bit6=g.
module hex_disp (
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   // Pure lookup; one instance is time-shared across all digits.
   always_comb begin
      o_seg = 7'h7F;
      unique case (i_nib)
         4'h0: o_seg = 7'h40;
         4'h1: o_seg = 7'h79;
         4'h2: o_seg = 7'h24;
         4'h3: o_seg = 7'h30;
         4'h4: o_seg = 7'h19;
         4'h5: o_seg = 7'h12;
         4'h6: o_seg = 7'h02;
         4'h7: o_seg = 7'h78;
         4'h8: o_seg = 7'h00;
         4'h9: o_seg = 7'h10;
         4'hA: o_seg = 7'h08;
         4'hB: o_seg = 7'h03;
         4'hC: o_seg = 7'h46;
         4'hD: o_seg = 7'h21;
         4'hE: o_seg = 7'h06;
         4'hF: o_seg = 7'h0E;
      endcase
   end

endmodule

module hex_scan_ctrl #(
   parameter int unsigned DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [15:0] wr_data,
   input  logic [3:0]  wr_blank,
   input  logic        lz_en,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic [1:0]  digit_sel
);

   localparam int unsigned CntW = $clog2(DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
   localparam logic [CntW-1:0] CntInc = CntW'(1);

   typedef enum logic {StEmpty, StPending} state_t;

   logic [CntW-1:0] r_cnt;
   logic [1:0]      r_idx;
   state_t          r_state;
   state_t          w_state_d;
   logic [15:0]     r_disp;
   logic [15:0]     w_disp_d;
   logic [3:0]      r_blank;
   logic [3:0]      w_blank_d;
   logic [15:0]     r_pend_data;
   logic [15:0]     w_pend_data_d;
   logic [3:0]      r_pend_blank;
   logic [3:0]      w_pend_blank_d;

   logic            w_boundary;
   logic            w_xfer;
   logic [3:0]      w_nib;
   logic [6:0]      w_seg;
   logic [3:0]      w_lz_sup;
   logic            w_dark;

   assign w_boundary = (r_idx == 2'd3) && (r_cnt == CntMax);
   // Gated by rst so the port reads not-ready while reset is held.
   assign wr_ready   = (r_state == StEmpty) && !rst;
   assign w_xfer     = wr_valid && wr_ready;
   assign digit_sel  = r_idx;

   // Slot counter and digit index; idx advances when the slot counter wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= 2'd0;
      end else if (r_cnt == CntMax) begin
         r_cnt <= '0;
         r_idx <= r_idx + 2'd1;
      end else begin
         r_cnt <= r_cnt + CntInc;
      end
   end

   // Handshake state, pending buffer and display registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StEmpty;
         r_disp       <= 16'h0000;
         r_blank      <= 4'b1111;
         r_pend_data  <= 16'h0000;
         r_pend_blank <= 4'b0000;
      end else begin
         r_state      <= w_state_d;
         r_disp       <= w_disp_d;
         r_blank      <= w_blank_d;
         r_pend_data  <= w_pend_data_d;
         r_pend_blank <= w_pend_blank_d;
      end
   end

   // Next-state: display registers only ever change on the boundary edge.
   always_comb begin
      w_state_d      = r_state;
      w_disp_d       = r_disp;
      w_blank_d      = r_blank;
      w_pend_data_d  = r_pend_data;
      w_pend_blank_d = r_pend_blank;
      unique case (r_state)
         StEmpty: begin
            if (w_xfer) begin
               if (w_boundary) begin
                  // Arrives exactly at the frame edge: skip the buffer.
                  w_disp_d  = wr_data;
                  w_blank_d = wr_blank;
               end else begin
                  w_pend_data_d  = wr_data;
                  w_pend_blank_d = wr_blank;
                  w_state_d      = StPending;
               end
            end
         end
         StPending: begin
            if (w_boundary) begin
               w_disp_d  = r_pend_data;
               w_blank_d = r_pend_blank;
               w_state_d = StEmpty;
            end
         end
      endcase
   end

   // Leading-zero suppression chain from the top digit down; digit 0 always shows.
   always_comb begin
      w_lz_sup    = 4'b0000;
      w_lz_sup[3] = lz_en && (r_disp[15:12] == 4'h0);
      w_lz_sup[2] = w_lz_sup[3] && (r_disp[11:8] == 4'h0);
      w_lz_sup[1] = w_lz_sup[2] && (r_disp[7:4] == 4'h0);
   end

   // Select the nibble of the digit being scanned.
   always_comb begin
      w_nib = 4'h0;
      unique case (r_idx)
         2'd0: w_nib = r_disp[3:0];
         2'd1: w_nib = r_disp[7:4];
         2'd2: w_nib = r_disp[11:8];
         2'd3: w_nib = r_disp[15:12];
      endcase
   end

   hex_disp u_hex_disp (
      .i_nib (w_nib),
      .o_seg (w_seg)
   );

   // cnt==0 is the anti-ghost gap; segments are also dark there.
   assign w_dark = (r_cnt == '0) || r_blank[r_idx] || w_lz_sup[r_idx];

   // Drive anodes and segments from registered state only.
   always_comb begin
      an  = 4'b1111;
      seg = 7'h7F;
      if (!w_dark) begin
         an  = ~(4'b0001 << r_idx);
         seg = w_seg;
      end
   end

endmodule
